// File: rtl/clkgate_pkg.sv
// Shared types and constants for the SM clock-gating sequencer.
// The optional statistics block is enabled with CLKGATE_STATS_EN.
package clkgate_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } state_e;

  localparam int unsigned STATS_CYC_W = 32;
  localparam int unsigned STATS_EVT_W = 16;

  typedef struct packed {
    logic gclk_en;
    logic quiesce_req;
    logic sm_ready;
  } ctl_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  // Moore output decode; WAKE keeps quiesce_req high so no work issues before sm_ready.
  function automatic ctl_t decode_ctl(input state_e s);
    ctl_t c;
    case (s)
      RUN:     c = '{gclk_en: 1'b1, quiesce_req: 1'b0, sm_ready: 1'b1};
      DRAIN:   c = '{gclk_en: 1'b1, quiesce_req: 1'b1, sm_ready: 1'b0};
      GATED:   c = '{gclk_en: 1'b0, quiesce_req: 1'b1, sm_ready: 1'b0};
      WAKE:    c = '{gclk_en: 1'b1, quiesce_req: 1'b1, sm_ready: 1'b0};
      default: c = '{gclk_en: 1'b1, quiesce_req: 1'b0, sm_ready: 1'b1};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/clkgate_stats.sv
// Gating statistics: gated-cycle count (saturating), gate and abort event counts (wrapping).
// Only instantiated when CLKGATE_STATS_EN is defined.
module clkgate_stats
  import clkgate_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gclk_en,
  input  logic                   gate_evt,
  input  logic                   drain_abort,
  output logic [STATS_CYC_W-1:0] gated_cycles,
  output logic [STATS_EVT_W-1:0] gate_events,
  output logic [STATS_EVT_W-1:0] abort_events
);

  logic [STATS_CYC_W-1:0] gated_cycles_q, gated_cycles_d;
  logic [STATS_EVT_W-1:0] gate_events_q, gate_events_d;
  logic [STATS_EVT_W-1:0] abort_events_q, abort_events_d;

  // Next-state for the three counters.
  always_comb begin
    gated_cycles_d = gated_cycles_q;
    gate_events_d  = gate_events_q;
    abort_events_d = abort_events_q;
    if (!gclk_en && (gated_cycles_q != {STATS_CYC_W{1'b1}})) begin
      gated_cycles_d = gated_cycles_q + STATS_CYC_W'(1);
    end else begin
      gated_cycles_d = gated_cycles_q;
    end
    if (gate_evt) begin
      gate_events_d = gate_events_q + STATS_EVT_W'(1);
    end else begin
      gate_events_d = gate_events_q;
    end
    if (drain_abort) begin
      abort_events_d = abort_events_q + STATS_EVT_W'(1);
    end else begin
      abort_events_d = abort_events_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gated_cycles_q <= {STATS_CYC_W{1'b0}};
      gate_events_q  <= {STATS_EVT_W{1'b0}};
      abort_events_q <= {STATS_EVT_W{1'b0}};
    end else begin
      gated_cycles_q <= gated_cycles_d;
      gate_events_q  <= gate_events_d;
      abort_events_q <= abort_events_d;
    end
  end

  assign gated_cycles = gated_cycles_q;
  assign gate_events  = gate_events_q;
  assign abort_events = abort_events_q;

endmodule

// File: rtl/sm_clk_gate_seq.sv
// Per-SM clock-gating sequencer: RUN -> DRAIN -> GATED -> WAKE -> RUN.
// Define CLKGATE_STATS_EN to add the gated_cycles/gate_events/abort_events outputs.
module sm_clk_gate_seq
  import clkgate_pkg::*;
#(
  parameter int unsigned DRAIN_TIMEOUT = 256,
  parameter int unsigned MIN_GATED     = 16,
  parameter int unsigned WAKE_CYCLES   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en_req,
  input  logic                   wake_req,
  input  logic                   sm_busy,
  input  logic                   quiesce_ack,
  output logic                   quiesce_req,
  output logic                   gclk_en,
  output logic                   sm_ready,
  output logic                   drain_abort,
  output logic [1:0]             state
`ifdef CLKGATE_STATS_EN
  ,
  output logic [STATS_CYC_W-1:0] gated_cycles,
  output logic [STATS_EVT_W-1:0] gate_events,
  output logic [STATS_EVT_W-1:0] abort_events
`endif
);

  localparam int unsigned CNT_MAX = max3(DRAIN_TIMEOUT, MIN_GATED, WAKE_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] GATED_LAST = CW'(MIN_GATED - 1);
  localparam logic [CW-1:0] WAKE_LAST  = CW'(WAKE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          clk_en_prev_q;
  logic          abort_q, abort_d;
  ctl_t          ctl_q, ctl_d;
  logic          gate_evt_s;
  logic          clk_en_rise_s;

  assign clk_en_rise_s = clk_en_req & ~clk_en_prev_q;

  // Next-state, shared counter, pend flag and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    abort_d = 1'b0;
    case (state_q)
      RUN: begin
        if (!clk_en_req && !wake_req) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (wake_req || clk_en_req) begin
          state_d = RUN;
        end else if (quiesce_ack && !sm_busy) begin
          state_d = GATED;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = RUN;
          abort_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GATED: begin
        if (clk_en_rise_s) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        // Urgent wake skips the dwell; a plain clk_en request waits for it.
        if (wake_req) begin
          state_d = WAKE;
        end else if (pend_q && (cnt_q >= GATED_LAST)) begin
          state_d = WAKE;
        end else if (cnt_q < GATED_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_d;
    end
    if ((state_d == WAKE) && (state_q != WAKE)) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_d;
    end

    gate_evt_s = (state_q == DRAIN) && (state_d == GATED);
    ctl_d      = decode_ctl(state_d);
  end

  // State, counter and output registers; outputs mirror the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= {CW{1'b0}};
      pend_q        <= 1'b0;
      clk_en_prev_q <= 1'b1;
      abort_q       <= 1'b0;
      ctl_q         <= decode_ctl(RUN);
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      clk_en_prev_q <= clk_en_req;
      abort_q       <= abort_d;
      ctl_q         <= ctl_d;
    end
  end

  assign state       = state_q;
  assign gclk_en     = ctl_q.gclk_en;
  assign quiesce_req = ctl_q.quiesce_req;
  assign sm_ready    = ctl_q.sm_ready;
  assign drain_abort = abort_q;

`ifdef CLKGATE_STATS_EN
  logic gate_evt_q;

  // Gate-event strobe aligned with the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_evt_q <= 1'b0;
    end else begin
      gate_evt_q <= gate_evt_s;
    end
  end

  clkgate_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .gclk_en      (ctl_q.gclk_en),
    .gate_evt     (gate_evt_q),
    .drain_abort  (abort_q),
    .gated_cycles (gated_cycles),
    .gate_events  (gate_events),
    .abort_events (abort_events)
  );
`else
  logic unused_s;
  assign unused_s = gate_evt_s;
`endif

endmodule

// File: tb/tb_sm_clk_gate_seq.sv
// Directed self-checking bench for sm_clk_gate_seq with default parameters.
module tb_sm_clk_gate_seq;

  logic       clk;
  logic       rst;
  logic       clk_en_req;
  logic       wake_req;
  logic       sm_busy;
  logic       quiesce_ack;
  logic       quiesce_req;
  logic       gclk_en;
  logic       sm_ready;
  logic       drain_abort;
  logic [1:0] state;
`ifdef CLKGATE_STATS_EN
  logic [31:0] gated_cycles;
  logic [15:0] gate_events;
  logic [15:0] abort_events;
`endif

  int n_chk;
  int n_pass;
  int n_fail;

  sm_clk_gate_seq dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en_req   (clk_en_req),
    .wake_req     (wake_req),
    .sm_busy      (sm_busy),
    .quiesce_ack  (quiesce_ack),
    .quiesce_req  (quiesce_req),
    .gclk_en      (gclk_en),
    .sm_ready     (sm_ready),
    .drain_abort  (drain_abort),
    .state        (state)
`ifdef CLKGATE_STATS_EN
    ,
    .gated_cycles (gated_cycles),
    .gate_events  (gate_events),
    .abort_events (abort_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic g,
                            input logic q, input logic r, input logic a);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".gclk_en"}, 32'(gclk_en), 32'(g));
    check({tag, ".quiesce_req"}, 32'(quiesce_req), 32'(q));
    check({tag, ".sm_ready"}, 32'(sm_ready), 32'(r));
    check({tag, ".drain_abort"}, 32'(drain_abort), 32'(a));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1; clk_en_req = 1'b0; wake_req = 1'b0; sm_busy = 1'b0; quiesce_ack = 1'b0;

    // Reset held 3 cycles with clk_en_req low
    tick(); tick(); tick();
    check_outs("reset", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    check_outs("post_reset_drain", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    clk_en_req = 1'b1;
    tick();
    check_outs("drain_cancel", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Clean gate: 0 -> 1 -> 2 on consecutive edges
    quiesce_ack = 1'b1; sm_busy = 1'b0; clk_en_req = 1'b0;
    tick();
    check_outs("gate_drain", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("gate_gated", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);

    // Hysteresis: clk_en_req rises 3 cycles into GATED, WAKE at dwell 16
    tick(); tick(); tick();
    clk_en_req = 1'b1;
    for (int i = 4; i <= 15; i++) begin
      tick();
      check("hyst_dwell.state", 32'(state), 32'd2);
    end
    tick();
    check_outs("hyst_wake", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    check_outs("hyst_wake_last", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("hyst_run", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Urgent wake one cycle into GATED
    clk_en_req = 1'b0;
    tick(); tick();
    check("uw_gated.state", 32'(state), 32'd2);
    tick();
    check("uw_gated1.state", 32'(state), 32'd2);
    wake_req = 1'b1;
    tick();
    check_outs("uw_wake", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    wake_req = 1'b0;
    quiesce_ack = 1'b0;
    tick(); tick(); tick();
    check("uw_wake_hold.sm_ready", 32'(sm_ready), 32'd0);
    tick();
    check_outs("uw_run", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Collision in DRAIN: wake_req with ack+idle must return to RUN
    tick();
    check("col_drain.state", 32'(state), 32'd1);
    quiesce_ack = 1'b1; sm_busy = 1'b0; wake_req = 1'b1;
    tick();
    check_outs("col_run", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    wake_req = 1'b0;

    // Drain timeout: 256 DRAIN cycles then one-cycle abort
    sm_busy = 1'b1;
    tick();
    check("to_enter.state", 32'(state), 32'd1);
    for (int i = 1; i <= 255; i++) begin
      tick();
      check("to_drain.state", 32'(state), 32'd1);
      check("to_drain.abort", 32'(drain_abort), 32'd0);
    end
    tick();
    check_outs("to_abort", 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    clk_en_req = 1'b1;
    tick();
    check_outs("to_after", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef CLKGATE_STATS_EN
    check("stats.abort_events", 32'(abort_events), 32'd1);
    check("stats.gate_events", 32'(gate_events), 32'd2);
    check("stats.gated_cycles", gated_cycles, 32'd18);
`endif

    // Reset while gated
    sm_busy = 1'b0; quiesce_ack = 1'b1; clk_en_req = 1'b0;
    tick(); tick();
    check("rg_gated.gclk_en", 32'(gclk_en), 32'd0);
    rst = 1'b1;
    tick();
    check_outs("rg_reset", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef CLKGATE_STATS_EN
    tick();
    check("rg_stats.gated_cycles", gated_cycles, 32'd0);
`endif
    rst = 1'b0; clk_en_req = 1'b1;
    tick();
    check("rg_run.state", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
